alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//   Shares one 8-bit ALU instance between two requesters over valid/ready handshakes.
//   Selects one request per cycle, round-robin on contention, and drives the ALU operands and func.
//   Registers the ALU result, tags it with the winning requester id, and holds it until the consumer accepts it.
//   Sits between the operand-issue logic and the writeback logic of the datapath.
// PARAMETERS
//   RR_EN    1  1 = round-robin on contention; 0 = fixed priority, req0 always wins
// PORTS
//   clk          in   1  single clock, rising edge
//   rst          in   1  synchronous, active-high reset
//   req0_valid   in   1  requester 0 has an operation
//   req0_ready   out  1  requester 0 operation accepted this cycle
//   req0_a       in   8  operand a
//   req0_b       in   8  operand b
//   req0_func    in   3  ALU function code
//   req1_*       --   -  same set as req0_* for requester 1
//   rsp_valid    out  1  result held
//   rsp_ready    in   1  consumer takes the result
//   rsp_data     out  8  registered ALU result
//   rsp_id       out  1  requester that issued the result (0/1)
//   rsp_zero     out  1  only with ALU_ZERO_FLAG_EN: rsp_data == 0
// BEHAVIOUR
//   - Reset (sync, rst=1 at a posedge) clears these registers:
//     - rsp_valid=0, rsp_data=8'h00, rsp_id=0, rsp_zero=0.
//     - last_grant=1, so req0 wins the first tie.
//     - FSM state = IDLE.
//   - While rst is high, req*_ready=0 and any held response is dropped.
//   - can_accept = !rsp_valid | rsp_ready (1-deep pipeline, throughput 1 op/cycle).
//   - grant:
//     - Only one valid: that requester.
//     - Both valid, RR_EN=1: the requester != last_grant.
//     - Both valid, RR_EN=0: req0.
//   - reqN_ready = grant==N & reqN_valid & can_accept & !rst; combinational, no dependency on rsp_ready beyond can_accept.
//   - Accept = valid&ready. On accept:
//     - The ALU sees the granted a/b/func in that cycle.
//     - At the next posedge: rsp_data <= ALU result, rsp_id <= grant, rsp_valid <= 1, last_grant <= grant.
//   - Latency: result is visible 1 cycle after accept.
//   - last_grant updates only on accept; a lone requester does not disturb fairness state.
//   - FSM:
//     - IDLE (rsp_valid=0): accept -> HOLD, else stay.
//     - HOLD (rsp_valid=1):
//       - rsp_ready & accept -> HOLD, new result loaded back-to-back.
//       - rsp_ready & !accept -> IDLE.
//       - !rsp_ready -> HOLD; rsp_data, rsp_id, rsp_zero stay stable, no accept.
//   - Arithmetic is ALU native, 8-bit, carry/borrow discarded:
//     - 000 add, 001 sub, 010 and, 011 xor, 100 not a, 101 a<<b, 110 a>>b, 111 -> 8'h00.
//     - Shift with b>=8 -> 8'h00.
//   - Protocol: a requester holds valid and operands stable until ready; operands are sampled only at accept.
//   - Simultaneous rsp_ready and a new accept in HOLD: the old result retires and the new one is loaded the same edge, with no bubble.
// CONFIGURATION
//   ALU_ZERO_FLAG_EN defined:
//     - Adds output port rsp_zero, registered with rsp_data: 1 iff ALU result == 0.
//     - rsp_zero resets to 0.
//   ALU_ZERO_FLAG_EN undefined: port and register are absent; all other behaviour is identical.
// STRUCTURE
//   Package alu_arb_pkg:
//     - func code constants FN_ADD..FN_SHR (3 bits).
//     - FSM state enum {IDLE, HOLD}.
//     - REQ_ID width constant (1).
//   One sub-module: the existing ALU (module ALU, ports a, b, func, c), instantiated once as u_alu; its operands are muxed by grant.
// TESTING
//   1. Reset: assert rst 2 cycles with req0_valid=1 -> req0_ready=0, rsp_valid=0, rsp_data=00, rsp_id=0 throughout.
//   2. Single op: req0 a=8'h0F b=8'h01 func=000, rsp_ready=1 -> ready same cycle; next cycle rsp_valid=1, rsp_data=8'h10, rsp_id=0.
//   3. Contention, RR_EN=1: both valid continuously, req0 sub 5-3, req1 xor AA^FF, rsp_ready=1 -> ids alternate 0,1,0,1; data 02,55,02,55; one result per cycle.
//   4. Backpressure: rsp_ready=0 for 3 cycles with a result held -> rsp_data stable, req*_ready=0; rsp_ready=1 then accepts the next op in that same cycle.
//   5. Edge ops: func=101 a=01 b=08 -> 00; func=111 -> 00; add FF+01 -> 00, with rsp_zero=1 when ALU_ZERO_FLAG_EN is defined.
//   6. Reset mid-op: rst while in HOLD with rsp_ready=0 -> next cycle rsp_valid=0; after rst drops, req0 wins the first tie.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared ALU function codes, arbiter FSM states and id width.
package alu_arb_pkg;
    localparam int REQ_ID_W = 1;
    localparam logic [2:0] FN_ADD = 3'b000;
    localparam logic [2:0] FN_SUB = 3'b001;
    localparam logic [2:0] FN_AND = 3'b010;
    localparam logic [2:0] FN_XOR = 3'b011;
    localparam logic [2:0] FN_NOT = 3'b100;
    localparam logic [2:0] FN_SHL = 3'b101;
    localparam logic [2:0] FN_SHR = 3'b110;
    typedef enum logic {IDLE, HOLD} state_e;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: two requester valid/ready channels plus the tagged response channel.
// rsp_zero exists only when ALU_ZERO_FLAG_EN is defined.
interface alu_arbiter_if;
    import alu_arb_pkg::*;
    logic                req0_valid;
    logic                req0_ready;
    logic [7:0]          req0_a;
    logic [7:0]          req0_b;
    logic [2:0]          req0_func;
    logic                req1_valid;
    logic                req1_ready;
    logic [7:0]          req1_a;
    logic [7:0]          req1_b;
    logic [2:0]          req1_func;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [7:0]          rsp_data;
    logic [REQ_ID_W-1:0] rsp_id;
`ifdef ALU_ZERO_FLAG_EN
    logic                rsp_zero;
`endif
    modport master (
        output req0_valid, req0_a, req0_b, req0_func,
        output req1_valid, req1_a, req1_b, req1_func, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
`ifdef ALU_ZERO_FLAG_EN
        , input rsp_zero
`endif
    );
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_func,
        input  req1_valid, req1_a, req1_b, req1_func, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
`ifdef ALU_ZERO_FLAG_EN
        , output rsp_zero
`endif
    );
endinterface

// File: rtl/ALU.sv
// ALU: 8-bit combinational ALU, carry/borrow discarded, shifts by 8 or more yield zero.
module ALU
    import alu_arb_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] func,
    output logic [7:0] c
);
    always_comb begin
        c = 8'h00;
        case (func)
            FN_ADD: c = a + b;
            FN_SUB: c = a - b;
            FN_AND: c = a & b;
            FN_XOR: c = a ^ b;
            FN_NOT: c = ~a;
            FN_SHL: c = (|b[7:3]) ? 8'h00 : a << b[2:0];
            FN_SHR: c = (|b[7:3]) ? 8'h00 : a >> b[2:0];
            default: c = 8'h00;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters and holds the tagged result until taken.
// Optional rsp_zero flag enabled by defining ALU_ZERO_FLAG_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);
    state_e              state_q, state_d;
    logic [7:0]          data_q, data_d;
    logic [REQ_ID_W-1:0] id_q, id_d, last_q, last_d, grant;
    logic [7:0]          alu_a, alu_b, alu_c;
    logic [2:0]          alu_func;
    logic                can_accept, accept;
`ifdef ALU_ZERO_FLAG_EN
    logic                zero_q, zero_d;
`endif

    ALU u_alu (.a(alu_a), .b(alu_b), .func(alu_func), .c(alu_c));

    always_comb begin
        can_accept = (state_q == IDLE) | bus.rsp_ready;
        grant = (bus.req0_valid & bus.req1_valid) ? (RR_EN ? ~last_q : '0) : bus.req1_valid;
        bus.req0_ready = ~grant[0] & bus.req0_valid & can_accept & ~rst;
        bus.req1_ready = grant[0] & bus.req1_valid & can_accept & ~rst;
        accept = bus.req0_ready | bus.req1_ready;
        alu_a = grant[0] ? bus.req1_a : bus.req0_a;
        alu_b = grant[0] ? bus.req1_b : bus.req0_b;
        alu_func = grant[0] ? bus.req1_func : bus.req0_func;
        // A new accept always lands in HOLD; an unaccepted held result stays put.
        state_d = (accept | (state_q == HOLD & ~bus.rsp_ready)) ? HOLD : IDLE;
        data_d = accept ? alu_c : data_q;
        id_d = accept ? grant : id_q;
        last_d = accept ? grant : last_q;
`ifdef ALU_ZERO_FLAG_EN
        zero_d = accept ? (alu_c == 8'h00) : zero_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= 8'h00;
            id_q    <= '0;
            last_q  <= '1;
`ifdef ALU_ZERO_FLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            last_q  <= last_d;
`ifdef ALU_ZERO_FLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign bus.rsp_valid = (state_q == HOLD);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_id    = id_q;
`ifdef ALU_ZERO_FLAG_EN
    assign bus.rsp_zero  = zero_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of reset, arbitration, backpressure, ALU edge ops and mid-op reset.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   passes = 0;
    int   total = 0;

    alu_arbiter_if bus ();
    alu_arbiter #(.RR_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    endtask

    task automatic chk_rsp(input string tag, input logic [7:0] data, input logic id);
        chk1({tag, "_valid"}, bus.rsp_valid, 1'b1);
        chk8({tag, "_data"}, bus.rsp_data, data);
        chk1({tag, "_id"}, bus.rsp_id, id);
    endtask

    // func, a, b, expected result
    logic [2:0] ev_f [8] = '{3'b101, 3'b111, 3'b000, 3'b100, 3'b101, 3'b110, 3'b010, 3'b110};
    logic [7:0] ev_a [8] = '{8'h01, 8'h5A, 8'hFF, 8'h0F, 8'h01, 8'h80, 8'h2A, 8'hFF};
    logic [7:0] ev_b [8] = '{8'h08, 8'h3C, 8'h01, 8'h00, 8'h07, 8'h03, 8'h0F, 8'h09};
    logic [7:0] ev_c [8] = '{8'h00, 8'h00, 8'h00, 8'hF0, 8'h80, 8'h10, 8'h0A, 8'h00};

    initial begin
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 8'h0F; bus.req0_b = 8'h01; bus.req0_func = 3'b000;
        bus.req1_valid = 1'b0; bus.req1_a = 8'h00; bus.req1_b = 8'h00; bus.req1_func = 3'b000;
        bus.rsp_ready = 1'b1;

        // 1: reset held two cycles with req0 valid
        for (int i = 0; i < 2; i++) begin
            tick();
            chk1("rst_rdy0", bus.req0_ready, 1'b0);
            chk1("rst_valid", bus.rsp_valid, 1'b0);
            chk8("rst_data", bus.rsp_data, 8'h00);
            chk1("rst_id", bus.rsp_id, 1'b0);
        end

        // 2: single add 0F+01
        rst = 1'b0;
        #1;
        chk1("single_rdy0", bus.req0_ready, 1'b1);
        chk1("single_rdy1", bus.req1_ready, 1'b0);
        tick();
        chk_rsp("single", 8'h10, 1'b0);
        bus.req0_valid = 1'b0;
        tick();
        chk1("single_retire", bus.rsp_valid, 1'b0);

        // 3: contention, round-robin from a fresh reset
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 8'h05; bus.req0_b = 8'h03; bus.req0_func = 3'b001;
        bus.req1_valid = 1'b1; bus.req1_a = 8'hAA; bus.req1_b = 8'hFF; bus.req1_func = 3'b011;
        tick();
        rst = 1'b0;
        #1;
        chk1("rr_first_rdy0", bus.req0_ready, 1'b1);
        chk1("rr_first_rdy1", bus.req1_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_rsp("rr", (i % 2 == 0) ? 8'h02 : 8'h55, (i % 2 == 1));
            chk1("rr_next_rdy1", bus.req1_ready, (i % 2 == 0));
        end

        // 4: backpressure holds id1/55 for three cycles
        bus.rsp_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk1("bp_rdy0", bus.req0_ready, 1'b0);
            chk1("bp_rdy1", bus.req1_ready, 1'b0);
            tick();
            chk_rsp("bp_hold", 8'h55, 1'b1);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk1("bp_release_rdy0", bus.req0_ready, 1'b1);
        tick();
        chk_rsp("bp_release", 8'h02, 1'b0);

        // 5: ALU edge ops issued back-to-back from req0 alone
        bus.req1_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.req0_func = ev_f[i]; bus.req0_a = ev_a[i]; bus.req0_b = ev_b[i];
            #1;
            chk1("edge_rdy0", bus.req0_ready, 1'b1);
            tick();
            chk_rsp("edge", ev_c[i], 1'b0);
`ifdef ALU_ZERO_FLAG_EN
            chk1("edge_zero", bus.rsp_zero, ev_c[i] == 8'h00);
`endif
        end

        // 6: reset while a result is held under backpressure
        bus.rsp_ready = 1'b0;
        bus.req1_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk1("mid_rst_rdy0", bus.req0_ready, 1'b0);
        chk1("mid_rst_rdy1", bus.req1_ready, 1'b0);
        tick();
        chk1("mid_rst_valid", bus.rsp_valid, 1'b0);
        chk8("mid_rst_data", bus.rsp_data, 8'h00);
`ifdef ALU_ZERO_FLAG_EN
        chk1("mid_rst_zero", bus.rsp_zero, 1'b0);
`endif
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req0_func = 3'b000; bus.req0_a = 8'h01; bus.req0_b = 8'h01;
        bus.req1_func = 3'b010; bus.req1_a = 8'hF0; bus.req1_b = 8'h0F;
        #1;
        chk1("post_rst_rdy0", bus.req0_ready, 1'b1);
        chk1("post_rst_rdy1", bus.req1_ready, 1'b0);
        tick();
        chk_rsp("post_rst", 8'h02, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
